// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: walks T0..T7 through fetch/execute and decodes IR[31:27] into datapath strobes.
// Outputs are combinational in state and opcode; T1, ld-T6 and st-T7 hold until mem_ready.
module control_unit #(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    state_t          state_q, state_d;
    logic [OPW-1:0]  opcode;
    logic            is_alu, is_imm, is_ldi, is_ld, is_st, is_halt, is_mem;
    logic [4:0]      imm_alu;
    logic            unused_ir;

    assign opcode    = IR[31:32-OPW];
    assign unused_ir = ^IR[31-OPW:0];

    always_comb begin
        is_alu  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
        is_imm  = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
        is_ldi  = (opcode == OP_LDI);
        is_ld   = (opcode == OP_LD);
        is_st   = (opcode == OP_ST);
        is_halt = (opcode == OP_HALT);
        is_mem  = is_ld || is_st;
        imm_alu = 5'(OP_ADD);
        if (opcode == OP_ANDI) imm_alu = 5'(OP_AND);
        if (opcode == OP_ORI)  imm_alu = 5'(OP_OR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_ready ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu || is_imm || is_ldi || is_mem) state_d = S_T4;
                else if (is_halt)                         state_d = S_HALT;
                else                                      state_d = S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_mem ? S_T6 : S_T0;
            S_T6: begin
                if (is_ld)      state_d = mem_ready ? S_T7 : S_T6;
                else if (is_st) state_d = S_T7;
                else            state_d = S_T0;
            end
            S_T7:   state_d = (is_st && !mem_ready) ? S_T7 : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Cout = 1'b0; Read = 1'b0; Write = 1'b0; alu_op = 5'd0; Run = 1'b0;
        case (state_q)
            S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                Run = 1'b1;
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldi || is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                Zin = 1'b1;
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; alu_op = 5'(opcode);
                end else if (is_imm) begin
                    Cout = 1'b1; alu_op = imm_alu;
                end else begin
                    Cout = 1'b1; alu_op = 5'(OP_ADD);
                end
            end
            S_T5: begin
                Run = 1'b1; Zlowout = 1'b1;
                if (is_mem) MARin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            // st stages the source register into MDR; ld waits on the read
            S_T6: begin
                Run = 1'b1; MDRin = 1'b1;
                if (is_st) begin Gra = 1'b1; Rout = 1'b1; end
                else       Read = 1'b1;
            end
            S_T7: begin
                Run = 1'b1; MDRout = 1'b1;
                if (is_st) Write = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: checks the full output vector against hand-built masks per T-state.
module tb_control_unit;
    logic clk, reset, mem_ready;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin;
    logic MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, Run;
    logic [4:0] alu_op;
    logic [24:0] obs;
    int checks = 0, passes = 0, cyc = 0, t0;

    localparam logic [24:0] GRA  = 25'd1 << 24, GRB   = 25'd1 << 23, GRC  = 25'd1 << 22;
    localparam logic [24:0] RIN  = 25'd1 << 21, ROUT  = 25'd1 << 20, BAO  = 25'd1 << 19;
    localparam logic [24:0] PCO  = 25'd1 << 18, PCIN  = 25'd1 << 17, INC  = 25'd1 << 16;
    localparam logic [24:0] MARI = 25'd1 << 15, MDRI  = 25'd1 << 14, MDRO = 25'd1 << 13;
    localparam logic [24:0] IRI  = 25'd1 << 12, YIN   = 25'd1 << 11, ZIN  = 25'd1 << 10;
    localparam logic [24:0] ZLO  = 25'd1 << 9,  COUT  = 25'd1 << 8,  RD   = 25'd1 << 7;
    localparam logic [24:0] WR   = 25'd1 << 6,  RUN   = 25'd1;
    localparam logic [24:0] E_T0 = RUN | PCO | MARI | INC | ZIN;
    localparam logic [24:0] E_T1 = RUN | ZLO | PCIN | RD | MDRI;
    localparam logic [24:0] E_T2 = RUN | MDRO | IRI;
    localparam logic [24:0] E_T5W = RUN | ZLO | GRA | RIN;

    control_unit #(.OPW(5)) dut (
        .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run)
    );

    assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                  MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, alu_op, Run};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [24:0] alu(input logic [4:0] op);
        return {19'd0, op, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [24:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_len(input string tag, input int exp);
        checks++;
        assert ((cyc - t0) === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, cyc - t0, exp);
    endtask

    // Starts in T0 (already checked), ends in T3 with the new IR.
    task automatic fetch(input logic [31:0] ir_val);
        t0 = cyc;
        mem_ready = 1'b1;
        step(); chk("fetch_T1", E_T1);
        IR = ir_val;
        step(); chk("fetch_T2", E_T2);
        step();
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] ir_val,
                             input bit imm, input logic [4:0] exp_op);
        fetch(ir_val);
        chk({tag, "_T3"}, RUN | GRB | ROUT | YIN);
        step();
        chk({tag, "_T4"}, RUN | ZIN | alu(exp_op) | (imm ? COUT : (GRC | ROUT)));
        step(); chk({tag, "_T5"}, E_T5W);
        step(); chk({tag, "_T0"}, E_T0);
        chk_len({tag, "_len"}, 6);
    endtask

    initial begin
        reset = 1'b1; IR = 32'h1800_0000; mem_ready = 1'b1;
        #1;
        chk("reset_async", 25'd0);
        step(); chk("reset_hold", 25'd0);
        reset = 1'b0;
        step(); chk("first_T0", E_T0);

        alu_instr("add",  32'h1800_0000, 1'b0, 5'b00011);
        alu_instr("shra", 32'h5000_0000, 1'b0, 5'b01010);
        alu_instr("andi", 32'h6800_0000, 1'b1, 5'b00101);
        alu_instr("addi", 32'h6000_0000, 1'b1, 5'b00011);
        alu_instr("ori",  32'h7000_0000, 1'b1, 5'b00110);

        // ldi
        fetch(32'h0800_0000);
        chk("ldi_T3", RUN | GRB | BAO | YIN);
        step(); chk("ldi_T4", RUN | COUT | ZIN | alu(5'b00011));
        step(); chk("ldi_T5", E_T5W);
        step(); chk("ldi_T0", E_T0);
        chk_len("ldi_len", 6);

        // ld with a three-cycle read stall
        fetch(32'h0000_0000);
        chk("ld_T3", RUN | GRB | BAO | YIN);
        step(); chk("ld_T4", RUN | COUT | ZIN | alu(5'b00011));
        step(); chk("ld_T5", RUN | ZLO | MARI);
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            chk("ld_T6", RUN | RD | MDRI);
            step();
        end
        chk("ld_T7", RUN | MDRO | GRA | RIN);
        step(); chk("ld_T0", E_T0);
        chk_len("ld_len", 11);

        // st: T6 must not stall, T7 stalls two cycles
        fetch(32'h1000_0000);
        chk("st_T3", RUN | GRB | BAO | YIN);
        step(); chk("st_T4", RUN | COUT | ZIN | alu(5'b00011));
        step(); chk("st_T5", RUN | ZLO | MARI);
        step(); mem_ready = 1'b0;
        chk("st_T6", RUN | GRA | ROUT | MDRI);
        step();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            chk("st_T7", RUN | MDRO | WR);
            step();
        end
        chk("st_T0", E_T0);
        chk_len("st_len", 10);

        // nop
        fetch(32'hD000_0000);
        chk("nop_T3", RUN);
        step(); chk("nop_T0", E_T0);
        chk_len("nop_len", 4);

        // halt
        fetch(32'hD800_0000);
        chk("halt_T3", RUN);
        step(); chk("halt_enter", 25'd0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            IR = $urandom;
            step(); chk("halt_hold", 25'd0);
        end
        IR = 32'h1800_0000;
        reset = 1'b1; #1;
        chk("halt_reset", 25'd0);
        step(); reset = 1'b0;
        step(); chk("halt_restart_T0", E_T0);

        // reset while stalled in T1
        mem_ready = 1'b0;
        step(); chk("stall_T1a", E_T1);
        step(); chk("stall_T1b", E_T1);
        #2 reset = 1'b1;
        #1 chk("stall_async_reset", 25'd0);
        step(); chk("stall_reset_hold", 25'd0);
        reset = 1'b0; mem_ready = 1'b1;
        step(); chk("stall_restart_T0", E_T0);

        // undecoded opcode 11111 behaves as nop
        fetch(32'hF800_0000);
        chk("op1f_T3", RUN);
        step(); chk("op1f_T0", E_T0);
        chk_len("op1f_len", 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer: steps a T-state machine through instruction fetch and execute and drives the datapath strobes. Its outputs Gra/Grb/Grc, Rin, Rout and BAout feed the select-and-encode stage directly, and the rest drive the bus, ALU, PC, IR and memory interface. It stalls on memory accesses through a ready handshake and stops on `halt`.

## Interface
- `OPW`, 5: opcode width (IR[31:27]).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state RST.
- `IR` in 32: instruction register contents; only IR[31:27] is decoded.
- `mem_ready` in 1: memory completed the current Read/Write this cycle.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: register select/enable strobes to select-and-encode.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Cout` out 1 each: datapath strobes.
- `Read`, `Write` out 1 each: memory requests.
- `alu_op` out 5: ALU operation code (opcode encoding).
- `Run` out 1: high while executing, low in RST and HALT.

## Operation
- States: RST, T0–T7, HALT. State register is asynchronous-reset. All outputs are combinational in state and IR[31:27]. Any strobe not listed for a state is 0.
- RST: all outputs 0, including Run. The next edge after reset deasserts goes to T0.
- Fetch, all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 until `mem_ready`=1.
  - T2: MDRout, IRin.
  - T3 decodes the newly loaded IR.
- ALU reg-reg (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- Immediate (addi 01100, andi 01101, ori 01110):
  - Same as reg-reg except T4 uses Cout instead of Grc/Rout.
  - alu_op maps to 00011, 00101 or 00110 respectively.
- ldi 00001:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- ld 00000:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Stays in T6 until `mem_ready`.
  - T7: MDRout, Gra, Rin.
  - Then T0.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: MDRout, Write. Stays in T7 until `mem_ready`.
  - Then T0.
- nop 11010 and every undecoded opcode: T3 asserts nothing, then T0.
- halt 11011: T3 goes to HALT. HALT holds with all outputs 0 and Run=0 until reset.
- alu_op is 0 in every state other than T4.
- Never assert more than one bus driver (PCout, Zlowout, MDRout, Rout, BAout, Cout) in the same state.
- `mem_ready` is ignored outside T1, ld-T6 and st-T7.

## Timing
- One state per clock except the stall states T1, ld-T6 and st-T7.
- Zero-wait instruction lengths (edges from T0 entry back to T0):
  - ALU reg-reg, immediate, ldi: 6.
  - ld, st: 8.
  - nop: 4.
- Each stall cycle adds one cycle. Read/Write stay asserted continuously through the stall, and the state advances on the edge where `mem_ready`=1.
- IR changes on the edge leaving T2. T3 decode sees the new value combinationally.
- Reset mid-instruction, including during a stall: outputs go to 0 immediately (asynchronous). After release, the first edge goes to T0. No partial instruction resumes.
- HALT does not respond to `mem_ready` or IR changes.

## Test plan
- Reset, then IR=`add` (0x18000000 pattern, opcode 00011) with `mem_ready` tied high → state sequence T0,T1,T2,T3,T4,T5,T0. Check Grc+Rout and alu_op=00011 in T4, and Gra+Rin in T5.
- IR=`ld` with `mem_ready` held low 3 cycles in T6 → Read+MDRin high 4 cycles, T7 shows MDRout+Gra+Rin, total 11 cycles.
- IR=`st` with a 2-cycle stall in T7 → Write high 3 consecutive cycles. Rout and MDRout never high together in the same cycle.
- IR=`andi` → T4 has Cout=1, Grc=0, alu_op=00101. IR=`ldi` → T3 has BAout=1, T5 has Gra+Rin.
- IR=`halt` → Run falls after T3 and stays 0 for 20 cycles regardless of `mem_ready`. Asserting reset then returns Run=1 starting at T0.
- Assert reset asynchronously in T1 while stalled → all outputs 0 before the next edge. After release, fetch restarts at T0. Opcode 11111 behaves as nop (4 cycles).
